// File: rtl/div_8_bit_pkg.sv
// Shared constants and state encoding for the sequential unsigned divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_8_bit_pkg;

  // Quotient / divisor / remainder width; the dividend is twice this wide.
  localparam int DW = 8;

  // One quotient bit is produced per iteration.
  localparam int ITER = DW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_8_bit_step.sv
// One restoring-division step: compare the shifted partial remainder with the divisor, subtract if it fits.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
// Ports: rem_i  - (W+1)-bit partial remainder with the next dividend bit already shifted in
//        dvs_i  - W-bit divisor
//        rem_o  - next partial remainder (always below the divisor, so W bits suffice)
//        q_o    - quotient bit for this step
module div_8_bit_step
  import div_8_bit_pkg::*;
#(
  parameter int W = div_8_bit_pkg::DW
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  always_comb begin
    q_o   = (rem_i >= {1'b0, dvs_i});
    // Either branch leaves a value strictly below the divisor, so the top bit is always zero.
    rem_o = q_o ? W'(rem_i - {1'b0, dvs_i}) : rem_i[W-1:0];
  end

endmodule

// File: rtl/div_8_bit.sv
// Sequential unsigned divider, 2*DW-bit dividend by DW-bit divisor, restoring algorithm, MSB first.
// Latency: DW cycles from the accepting edge for a normal divide; 1 cycle for divide-by-zero or overflow.
// Backpressure: start is only looked at while busy=0; requests during a divide are dropped.
// Ports: clk, rst_n (async, active-low); start/dividend/divisor request; busy, done (1-cycle pulse),
//        quotient, remainder, overflow, div_by_zero results held from DONE until the next accepted start.
module div_8_bit
  import div_8_bit_pkg::*;
#(
  parameter int DW = div_8_bit_pkg::DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            overflow,
  output logic            div_by_zero
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] pr_q, pr_d;        // partial remainder (its 9th bit is always zero between steps)
  logic [DW-1:0] lo_q, lo_d;        // dividend low half, shifted left one bit per iteration
  logic [DW-1:0] dvs_q, dvs_d;
  logic [DW-2:0] qacc_q, qacc_d;    // quotient bits gathered so far, kept off the output until DONE
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] rem_q, rem_d;
  logic          ovf_q, ovf_d;
  logic          dbz_q, dbz_d;

  logic [DW-1:0] step_rem;
  logic          step_q;

  div_8_bit_step #(.W(DW)) u_step (
    .rem_i (({pr_q, lo_q[DW-1]})),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      qacc_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      qacc_q  <= qacc_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    qacc_d  = qacc_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_CALC;
          cnt_d   = '0;
          pr_d    = dividend[2*DW-1:DW];
          lo_d    = dividend[DW-1:0];
          dvs_d   = divisor;
          qacc_d  = '0;
          ovf_d   = 1'b0;
          dbz_d   = 1'b0;
        end
      end

      S_CALC: begin
        if ((cnt_q == '0) && (dvs_q == '0)) begin
          // lo_q has not been shifted yet, so it still holds the dividend low half.
          state_d = S_DONE;
          dbz_d   = 1'b1;
          quo_d   = '1;
          rem_d   = lo_q;
        end else if ((cnt_q == '0) && (pr_q >= dvs_q)) begin
          // High half already >= divisor: the quotient needs more than DW bits.
          state_d = S_DONE;
          ovf_d   = 1'b1;
          quo_d   = '1;
          rem_d   = pr_q;
        end else begin
          pr_d   = step_rem;
          lo_d   = {lo_q[DW-2:0], 1'b0};
          cnt_d  = cnt_q + 1'b1;
          if (DW > 2) begin
            qacc_d = {qacc_q[DW-3:0], step_q};
          end else begin
            qacc_d = step_q;
          end
          if (cnt_q == LAST) begin
            state_d = S_DONE;
            quo_d   = {qacc_q, step_q};
            rem_d   = step_rem;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q == S_CALC);
  assign done        = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule
